// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD rate timer.
// Holds the FSM state encoding, speed encodings and prescaler match points.
// No logic; imported by the divider and the timer core.
package timer_pkg;

  // Timer operating states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_UP   = 2'd1,
    ST_RUN_DOWN = 2'd2,
    ST_ALARM    = 2'd3
  } state_e;

  // Step-rate select encodings (3 aliases 1 Hz)
  localparam logic [1:0] SPD_1HZ     = 2'd0;
  localparam logic [1:0] SPD_2HZ     = 2'd1;
  localparam logic [1:0] SPD_4HZ     = 2'd2;
  localparam logic [1:0] SPD_1HZ_ALT = 2'd3;

  // Prescaler runs 0..19 on the 20 Hz tick
  localparam int unsigned PRE_W = 5;
  localparam logic [PRE_W-1:0] PRE_LAST   = 5'd19;
  localparam logic [PRE_W-1:0] PRE_Q1     = 5'd4;
  localparam logic [PRE_W-1:0] PRE_HALF   = 5'd9;
  localparam logic [PRE_W-1:0] PRE_Q3     = 5'd14;
  localparam logic [PRE_W-1:0] PRE_FINE_A = 5'd1;
  localparam logic [PRE_W-1:0] PRE_FINE_B = 5'd11;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Saturate a BCD digit at a limit (used when loading switch presets)
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Prescaler for the 20 Hz tick: produces 1/2/4 Hz step, fine-mode step and 2 Hz blink strobes.
// Strobes are combinational from the registered prescaler and the tick; zero added latency.
// hold_i freezes the prescaler and suppresses every strobe.
module tick_divider
  import timer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic hold_i,
  output logic step_1_o,
  output logic step_2_o,
  output logic step_4_o,
  output logic step_10_o,
  output logic blink_2_o
);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic             adv;

  assign adv = tick_i & ~hold_i;

  // Next prescaler value: wraps after the last phase, only on an unheld tick
  always_comb begin
    pre_d = pre_q;
    if (adv) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
    end
  end

  // Prescaler register with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign step_1_o  = adv & (pre_q == PRE_LAST);
  assign step_2_o  = adv & ((pre_q == PRE_HALF) | (pre_q == PRE_LAST));
  assign step_4_o  = adv & ((pre_q == PRE_Q1) | (pre_q == PRE_HALF) |
                            (pre_q == PRE_Q3) | (pre_q == PRE_LAST));
  assign step_10_o = adv & ((pre_q == PRE_FINE_A) | (pre_q == PRE_FINE_B));
  assign blink_2_o = step_2_o;

endmodule

// File: rtl/bcd_rate_timer.sv
// Two-digit BCD up/down timer with optional tenths digit, selectable step rate and alarm blink.
// All outputs registered: a step or command in cycle N shows on the outputs in cycle N+1.
// No handshake; pause holds digits and prescaler, commands are accepted in every state.
module bcd_rate_timer
  import timer_pkg::*;
#(
  parameter int unsigned TENS_MAX     = 5,
  parameter int unsigned ALARM_THRESH = 8,
  parameter int unsigned ALARM_BLINKS = 4,
  parameter bit          WRAP_DOWN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tick_20hz,
  input  logic       cmd_up,
  input  logic       cmd_down,
  input  logic       cmd_load,
  input  logic       pause,
  input  logic [1:0] speed,
  input  logic       fine,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [3:0] tenths,
  output logic       point,
  output logic       led,
  output logic       running,
  output logic       done
);

  localparam logic [3:0]        TMAX    = 4'(TENS_MAX);
  localparam logic [3:0]        THR     = 4'(ALARM_THRESH);
  localparam int unsigned       BC_W    = $clog2(2 * ALARM_BLINKS + 1);
  localparam logic [BC_W-1:0]   BC_LAST = BC_W'(2 * ALARM_BLINKS - 1);

  state_e          state_q;
  logic [3:0]      tens_q, ones_q, tenths_q;
  logic            point_q, led_q, running_q, done_q;
  logic [BC_W-1:0] blink_q;

  logic            step_1, step_2, step_4, step_10, blink_2;
  logic            step;
  logic [3:0]      ld_tens, ld_ones;
  logic [3:0]      inc_tens, inc_ones, inc_tenths;
  logic [3:0]      dec_tens, dec_ones, dec_tenths;
  logic            inc_carry, dec_borrow;
  logic            cur_zero, dec_zero, pre_win;

  // Prescaler and rate strobes; en low clears it along with everything else
  tick_divider u_div (
    .clk       (clk),
    .rst_n     (rst_n & en),
    .tick_i    (tick_20hz),
    .hold_i    (pause),
    .step_1_o  (step_1),
    .step_2_o  (step_2),
    .step_4_o  (step_4),
    .step_10_o (step_10),
    .blink_2_o (blink_2)
  );

  // Pick the step strobe for the current mode; fine mode ignores speed
  always_comb begin
    step = step_1;
    if (fine) begin
      step = step_10;
    end else begin
      case (speed)
        SPD_1HZ, SPD_1HZ_ALT: step = step_1;
        SPD_2HZ:              step = step_2;
        SPD_4HZ:              step = step_4;
      endcase
    end
  end

  assign ld_tens = clamp_digit(preset_tens, TMAX);
  assign ld_ones = clamp_digit(preset_ones, BCD_MAX);

  // BCD increment; the chain starts at tenths in fine mode, at ones otherwise
  always_comb begin
    inc_tens   = tens_q;
    inc_ones   = ones_q;
    inc_tenths = 4'd0;
    inc_carry  = 1'b1;
    if (fine) begin
      if (tenths_q >= BCD_MAX) begin
        inc_tenths = 4'd0;
      end else begin
        inc_tenths = tenths_q + 4'd1;
        inc_carry  = 1'b0;
      end
    end
    if (inc_carry) begin
      if (ones_q >= BCD_MAX) begin
        inc_ones = 4'd0;
      end else begin
        inc_ones  = ones_q + 4'd1;
        inc_carry = 1'b0;
      end
    end
    if (inc_carry) begin
      inc_tens = (tens_q >= TMAX) ? 4'd0 : tens_q + 4'd1;
    end
  end

  // BCD decrement; 00(.0) wraps to the top of range, saturation is handled by the FSM
  always_comb begin
    dec_tens   = tens_q;
    dec_ones   = ones_q;
    dec_tenths = 4'd0;
    dec_borrow = 1'b1;
    if (fine) begin
      if (tenths_q == 4'd0) begin
        dec_tenths = BCD_MAX;
      end else begin
        dec_tenths = tenths_q - 4'd1;
        dec_borrow = 1'b0;
      end
    end
    if (dec_borrow) begin
      if (ones_q == 4'd0) begin
        dec_ones = BCD_MAX;
      end else begin
        dec_ones   = ones_q - 4'd1;
        dec_borrow = 1'b0;
      end
    end
    if (dec_borrow) begin
      dec_tens = (tens_q == 4'd0) ? TMAX : tens_q - 4'd1;
    end
  end

  // Zero detection ignores a stale tenths digit when fine mode has just dropped
  assign cur_zero = (tens_q == 4'd0) && (ones_q == 4'd0) && (!fine || (tenths_q == 4'd0));
  assign dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0) && (dec_tenths == 4'd0);
  assign pre_win  = (tens_q == 4'd0) && (ones_q < THR);

  // Timer FSM with digit counters, blink counter and registered outputs
  always_ff @(posedge clk) begin
    if (!en || !rst_n) begin
      state_q   <= ST_IDLE;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      tenths_q  <= 4'd0;
      point_q   <= 1'b0;
      led_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      blink_q   <= '0;
    end else begin
      point_q <= fine;
      done_q  <= 1'b0;
      if (cmd_load) begin
        tens_q    <= ld_tens;
        ones_q    <= ld_ones;
        tenths_q  <= 4'd0;
        state_q   <= ST_IDLE;
        led_q     <= 1'b0;
        blink_q   <= '0;
        running_q <= 1'b0;
      end else if (cmd_down) begin
        tens_q    <= ld_tens;
        ones_q    <= ld_ones;
        tenths_q  <= 4'd0;
        state_q   <= ST_RUN_DOWN;
        led_q     <= 1'b0;
        blink_q   <= '0;
        running_q <= !pause;
      end else if (cmd_up) begin
        tens_q    <= 4'd0;
        ones_q    <= 4'd0;
        tenths_q  <= 4'd0;
        state_q   <= ST_RUN_UP;
        led_q     <= 1'b0;
        blink_q   <= '0;
        running_q <= !pause;
      end else begin
        if (!fine) begin
          tenths_q <= 4'd0;
        end
        case (state_q)
          ST_IDLE: begin
            led_q     <= 1'b0;
            running_q <= 1'b0;
          end
          ST_RUN_UP: begin
            led_q     <= 1'b0;
            running_q <= !pause;
            if (step) begin
              tens_q   <= inc_tens;
              ones_q   <= inc_ones;
              tenths_q <= inc_tenths;
            end
          end
          ST_RUN_DOWN: begin
            running_q <= !pause;
            if (!pre_win) begin
              led_q <= 1'b0;
            end else if (blink_2) begin
              led_q <= !led_q;
            end
            if (step) begin
              if (!WRAP_DOWN && (cur_zero || dec_zero)) begin
                tens_q    <= 4'd0;
                ones_q    <= 4'd0;
                tenths_q  <= 4'd0;
                done_q    <= 1'b1;
                state_q   <= ST_ALARM;
                led_q     <= 1'b0;
                blink_q   <= '0;
                running_q <= 1'b0;
              end else begin
                tens_q   <= dec_tens;
                ones_q   <= dec_ones;
                tenths_q <= dec_tenths;
              end
            end
          end
          ST_ALARM: begin
            running_q <= 1'b0;
            if (blink_2) begin
              if (blink_q == BC_LAST) begin
                led_q   <= 1'b0;
                blink_q <= '0;
                state_q <= ST_IDLE;
              end else begin
                led_q   <= !led_q;
                blink_q <= blink_q + BC_W'(1);
              end
            end
          end
        endcase
      end
    end
  end

  assign tens    = tens_q;
  assign ones    = ones_q;
  assign tenths  = tenths_q;
  assign point   = point_q;
  assign led     = led_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_rate_timer.sv
// Randomised plus directed bench for bcd_rate_timer with a scoreboard.
// Two instances: default parameters, and a small wrapping variant.
// Expected outputs come from an integer-tenths reference model.
module tb_bcd_rate_timer;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] tenths;
    logic       point;
    logic       led;
    logic       running;
    logic       done;
  } obs_t;

  typedef struct {
    int   tgt;
    obs_t o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, en, tick_20hz, cmd_up, cmd_down, cmd_load, pause, fine;
  logic [1:0] speed;
  logic [3:0] preset_tens, preset_ones;
  logic [3:0] t0, o0, f0, t1, o1, f1;
  logic       p0, l0, r0, d0, p1, l1, r1, d1;
  obs_t       obs0, obs1;

  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  bcd_rate_timer u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .tick_20hz(tick_20hz),
    .cmd_up(cmd_up), .cmd_down(cmd_down), .cmd_load(cmd_load), .pause(pause),
    .speed(speed), .fine(fine), .preset_tens(preset_tens), .preset_ones(preset_ones),
    .tens(t0), .ones(o0), .tenths(f0), .point(p0), .led(l0), .running(r0), .done(d0)
  );

  bcd_rate_timer #(
    .TENS_MAX(2), .ALARM_THRESH(3), .ALARM_BLINKS(2), .WRAP_DOWN(1'b1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .tick_20hz(tick_20hz),
    .cmd_up(cmd_up), .cmd_down(cmd_down), .cmd_load(cmd_load), .pause(pause),
    .speed(speed), .fine(fine), .preset_tens(preset_tens), .preset_ones(preset_ones),
    .tens(t1), .ones(o1), .tenths(f1), .point(p1), .led(l1), .running(r1), .done(d1)
  );

  assign obs0 = {t0, o0, f0, p0, l0, r0, d0};
  assign obs1 = {t1, o1, f1, p1, l1, r1, d1};

  // Reference model: the count is one integer in tenths of a second
  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_ALARM = 3;
  int cfg_tm   [2] = '{5, 2};
  int cfg_th   [2] = '{8, 3};
  int cfg_bl   [2] = '{4, 2};
  int cfg_wrap [2] = '{0, 1};
  int m_t [2];
  int m_st [2];
  int m_p [2];
  int m_toggles [2];
  bit m_led [2];
  bit m_done [2];
  bit m_run [2];
  bit m_point [2];

  task automatic model_one(input int i);
    int  span, s, ph, ct, co;
    bit  adv, stp, blink;
    span  = (cfg_tm[i] + 1) * 100;
    s     = fine ? 1 : 10;
    ph    = m_p[i];
    adv   = tick_20hz && !pause;
    if (fine)              stp = adv && (ph == 1 || ph == 11);
    else if (speed == 2'd1) stp = adv && (ph % 10 == 9);
    else if (speed == 2'd2) stp = adv && (ph % 5 == 4);
    else                   stp = adv && (ph == 19);
    blink = adv && (ph % 10 == 9);
    if (!en || !rst_n) begin
      m_t[i] = 0; m_st[i] = M_IDLE; m_p[i] = 0; m_toggles[i] = 0;
      m_led[i] = 0; m_done[i] = 0; m_run[i] = 0; m_point[i] = 0;
    end else begin
      if (adv) m_p[i] = (ph + 1) % 20;
      m_point[i] = fine;
      m_done[i]  = 0;
      ct = (int'(preset_tens) > cfg_tm[i]) ? cfg_tm[i] : int'(preset_tens);
      co = (int'(preset_ones) > 9) ? 9 : int'(preset_ones);
      if (cmd_load || cmd_down || cmd_up) begin
        m_led[i] = 0;
        m_toggles[i] = 0;
        if (cmd_load) begin
          m_t[i] = (ct * 10 + co) * 10; m_st[i] = M_IDLE;
        end else if (cmd_down) begin
          m_t[i] = (ct * 10 + co) * 10; m_st[i] = M_DOWN;
        end else begin
          m_t[i] = 0; m_st[i] = M_UP;
        end
      end else begin
        if (!fine) m_t[i] = m_t[i] - (m_t[i] % 10);
        case (m_st[i])
          M_UP: begin
            m_led[i] = 0;
            if (stp) m_t[i] = (m_t[i] + s) % span;
          end
          M_DOWN: begin
            if (m_t[i] / 100 == 0 && (m_t[i] / 10) % 10 < cfg_th[i]) begin
              if (blink) m_led[i] = !m_led[i];
            end else begin
              m_led[i] = 0;
            end
            if (stp) begin
              if (cfg_wrap[i] != 0) begin
                m_t[i] = (m_t[i] - s + span) % span;
              end else begin
                m_t[i] = m_t[i] - s;
                if (m_t[i] <= 0) begin
                  m_t[i] = 0; m_done[i] = 1; m_st[i] = M_ALARM;
                  m_led[i] = 0; m_toggles[i] = 0;
                end
              end
            end
          end
          M_ALARM: begin
            if (blink) begin
              m_toggles[i] = m_toggles[i] + 1;
              if (m_toggles[i] == 2 * cfg_bl[i]) begin
                m_led[i] = 0; m_st[i] = M_IDLE; m_toggles[i] = 0;
              end else begin
                m_led[i] = !m_led[i];
              end
            end
          end
          default: m_led[i] = 0;
        endcase
      end
      m_run[i] = (m_st[i] == M_UP || m_st[i] == M_DOWN) && !pause;
    end
  endtask

  // Advance the model with the inputs now driven, queue the expectation, then clock
  task automatic step_cycle();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      model_one(i);
      e.tgt = edge_cnt + 1;
      e.o   = {4'(m_t[i] / 100), 4'((m_t[i] / 10) % 10), 4'(m_t[i] % 10),
               m_point[i], m_led[i], m_run[i], m_done[i]};
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) step_cycle();
  endtask

  task automatic run_ticks(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      tick_20hz = 1'b1;
      step_cycle();
      tick_20hz = 1'b0;
      for (int g = 0; g < gap; g++) step_cycle();
    end
  endtask

  task automatic cmd_pulse(input bit up, input bit down, input bit load);
    cmd_up = up; cmd_down = down; cmd_load = load;
    step_cycle();
    cmd_up = 1'b0; cmd_down = 1'b0; cmd_load = 1'b0;
  endtask

  task automatic check(input int i, input obs_t want, input obs_t got);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL outputs dut%0d edge %0d: got tens=%0d ones=%0d tenths=%0d point=%b led=%b running=%b done=%b, want tens=%0d ones=%0d tenths=%0d point=%b led=%b running=%b done=%b",
               i, edge_cnt, got.tens, got.ones, got.tenths, got.point, got.led, got.running, got.done,
               want.tens, want.ones, want.tenths, want.point, want.led, want.running, want.done);
    end
  endtask

  // Monitor: compare every expectation whose clock edge has already happened
  always @(negedge clk) begin
    exp_t e;
    while (q0.size() > 0 && q0[0].tgt <= edge_cnt) begin
      e = q0.pop_front();
      check(0, e.o, obs0);
    end
    while (q1.size() > 0 && q1[0].tgt <= edge_cnt) begin
      e = q1.pop_front();
      check(1, e.o, obs1);
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; tick_20hz = 1'b0;
    cmd_up = 1'b0; cmd_down = 1'b0; cmd_load = 1'b0;
    pause = 1'b0; speed = 2'd0; fine = 1'b0;
    preset_tens = 4'd0; preset_ones = 4'd0;
    for (int i = 0; i < 2; i++) begin
      m_t[i] = 0; m_st[i] = M_IDLE; m_p[i] = 0; m_toggles[i] = 0;
      m_led[i] = 0; m_done[i] = 0; m_run[i] = 0; m_point[i] = 0;
    end
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(2);

    // Up count through a full minute and the wrap to 00
    cmd_pulse(1'b1, 1'b0, 1'b0);
    run_ticks(1210, 1);

    // Countdown 12 at 4 Hz to expiry, then the alarm blink back to IDLE
    preset_tens = 4'd1; preset_ones = 4'd2; speed = 2'd2;
    cmd_pulse(1'b0, 1'b1, 1'b0);
    run_ticks(340, 1);

    // Clamped preset load, then a long countdown (second instance wraps)
    preset_tens = 4'd9; preset_ones = 4'd12;
    cmd_pulse(1'b0, 1'b0, 1'b1);
    idle_cycles(3);
    cmd_pulse(1'b0, 1'b1, 1'b0);
    run_ticks(320, 1);

    // Fine mode countdown from 01.0, then drop fine during the alarm
    preset_tens = 4'd0; preset_ones = 4'd1; fine = 1'b1;
    cmd_pulse(1'b0, 1'b1, 1'b0);
    run_ticks(120, 1);
    fine = 1'b0;
    run_ticks(60, 1);
    fine = 1'b1;
    cmd_pulse(1'b1, 1'b0, 1'b0);
    run_ticks(37, 2);
    fine = 1'b0;
    run_ticks(30, 1);

    // Pause mid-run, then release
    speed = 2'd1;
    cmd_pulse(1'b1, 1'b0, 1'b0);
    run_ticks(50, 1);
    pause = 1'b1;
    run_ticks(30, 1);
    pause = 1'b0;
    run_ticks(20, 1);

    // Same-cycle load and up: load wins
    preset_tens = 4'd3; preset_ones = 4'd4;
    cmd_pulse(1'b1, 1'b0, 1'b1);
    run_ticks(10, 1);

    // Command together with pause: state set, count held until release
    pause = 1'b1;
    cmd_pulse(1'b0, 1'b1, 1'b0);
    run_ticks(15, 1);
    pause = 1'b0;
    run_ticks(15, 1);

    // Reach ALARM, then reset during it; repeat with en low
    preset_tens = 4'd0; preset_ones = 4'd2; speed = 2'd2;
    cmd_pulse(1'b0, 1'b1, 1'b0);
    run_ticks(45, 1);
    rst_n = 1'b0;
    step_cycle();
    rst_n = 1'b1;
    idle_cycles(2);
    cmd_pulse(1'b0, 1'b1, 1'b0);
    run_ticks(45, 1);
    en = 1'b0;
    step_cycle();
    en = 1'b1;
    idle_cycles(2);

    // Randomised traffic, biased towards short countdowns
    for (int k = 0; k < 5000; k++) begin
      tick_20hz = ($urandom_range(0, 2) == 0);
      cmd_up    = ($urandom_range(0, 299) == 0);
      cmd_down  = ($urandom_range(0, 199) == 0);
      cmd_load  = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 59) == 0)  pause = ~pause;
      if ($urandom_range(0, 149) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 249) == 0) fine = ~fine;
      preset_tens = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      preset_ones = 4'($urandom_range(0, 15));
      en    = ($urandom_range(0, 999) != 0);
      rst_n = ($urandom_range(0, 1199) != 0);
      step_cycle();
    end
    tick_20hz = 1'b0; cmd_up = 1'b0; cmd_down = 1'b0; cmd_load = 1'b0;
    en = 1'b1; rst_n = 1'b1;
    idle_cycles(3);

    @(negedge clk);
    #1;
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d expectations left, want 0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
